// File: rtl/alu_result_pkg.sv
// Shared types for the ALU result collector: result class codes, drop counter width, FIFO entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package alu_result_pkg;

  // Class code carried alongside each result; also the OUT_TAG encoding.
  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_CMP   = 2'b10,
    CLS_SHIFT = 2'b11
  } cls_t;

  localparam int DROP_CNT_W = 8;

  // Entry data width equals the arith result width (the widest ALU output).
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    cls_t                    tag;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_result_collector_fifo.sv
// Synchronous FIFO with first-word-fall-through head, full/empty decodes from a registered count.
// Latency: a write is visible at the head one cycle later; a read removes the head on the same edge.
// Backpressure: writes are ignored when full unless a read happens on the same edge; reads of an empty FIFO are ignored.
//
// Ports: clk/rst (async active-high), wr_vld/wr_dat write side, rd_rdy pops the head,
//        rd_dat head entry (0 when empty), empty/full status.
module result_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_rdy,
  output logic [DATA_W-1:0] rd_dat,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop on the same edge frees the slot the write will use, so a full FIFO still accepts.
  assign do_rd = rd_rdy && !empty;
  assign do_wr = wr_vld && (!full || do_rd);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a non-empty count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_result_collector.sv
// Collects flag-qualified ALU results (priority arith > logic > cmp > shift) into a tagged FIFO stream.
// Latency: 1 cycle from a sampled flag to OUT_VALID/OUT_DATA when the FIFO is empty.
// Backpressure: OUT_VALID/OUT_READY drain; a candidate arriving at full with no pop is dropped and counted.
//
// Ports: CLK, RST (async active-high); Arith/Logic/CMP/SHIFT _OUT + _Flag from ALU_TOP;
//        OUT_DATA/OUT_TAG/OUT_VALID/OUT_READY result stream; FIFO_FULL, DROP_CNT (saturating), MULTI_ERR (sticky).
// Build option: define ALU_RESULT_DEDUP_EN to suppress candidates equal to the last accepted {class, data}.
module alu_result_collector
  import alu_result_pkg::*;
#(
  parameter int WIDTH_OUT_DATA_ARITH = 32,
  parameter int WIDTH_OUT_DATA_LOGIC = 16,
  parameter int WIDTH_OUT_DATA_CMP   = 16,
  parameter int WIDTH_OUT_DATA_SHIFT = 16,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [WIDTH_OUT_DATA_ARITH-1:0] Arith_OUT,
  input  logic [WIDTH_OUT_DATA_LOGIC-1:0] Logic_OUT,
  input  logic [WIDTH_OUT_DATA_CMP-1:0]   CMP_OUT,
  input  logic [WIDTH_OUT_DATA_SHIFT-1:0] SHIFT_OUT,
  input  logic                            Arith_Flag,
  input  logic                            Logic_Flag,
  input  logic                            CMP_Flag,
  input  logic                            SHIFT_Flag,
  output logic [WIDTH_OUT_DATA_ARITH-1:0] OUT_DATA,
  output logic [1:0]                      OUT_TAG,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic                            FIFO_FULL,
  output logic [DROP_CNT_W-1:0]           DROP_CNT,
  output logic                            MULTI_ERR
);

  entry_t cand;
  logic   cand_vld;
  logic   multi_hit;
  logic   is_new;
  logic   push_req;
  logic   push_ok;
  logic   pop;
  logic   drop;
  logic   fifo_empty;
  logic   fifo_full;
  entry_t head;

  // Priority select with zero-extension of the narrower results.
  always_comb begin
    cand     = '0;
    cand_vld = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
    if (Arith_Flag) begin
      cand.tag  = CLS_ARITH;
      cand.data = ENTRY_DATA_W'(Arith_OUT);
    end else if (Logic_Flag) begin
      cand.tag  = CLS_LOGIC;
      cand.data = ENTRY_DATA_W'(Logic_OUT);
    end else if (CMP_Flag) begin
      cand.tag  = CLS_CMP;
      cand.data = ENTRY_DATA_W'(CMP_OUT);
    end else if (SHIFT_Flag) begin
      cand.tag  = CLS_SHIFT;
      cand.data = ENTRY_DATA_W'(SHIFT_OUT);
    end
  end

  // Any pair of flags high at once.
  assign multi_hit = (Arith_Flag & (Logic_Flag | CMP_Flag | SHIFT_Flag)) |
                     (Logic_Flag & (CMP_Flag | SHIFT_Flag)) |
                     (CMP_Flag & SHIFT_Flag);

`ifdef ALU_RESULT_DEDUP_EN
  // History tracks the last entry actually written, so drops never update it.
  entry_t hist;
  logic   hist_vld;

  assign is_new = !hist_vld || (hist != cand);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist     <= '0;
      hist_vld <= 1'b0;
    end else if (push_ok) begin
      hist     <= cand;
      hist_vld <= 1'b1;
    end
  end
`else
  assign is_new = 1'b1;
`endif

  assign pop      = !fifo_empty && OUT_READY;
  assign push_req = cand_vld && is_new;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DROP_CNT  <= '0;
      MULTI_ERR <= 1'b0;
    end else begin
      if (drop)      DROP_CNT  <= sat_inc(DROP_CNT);
      if (multi_hit) MULTI_ERR <= 1'b1;
    end
  end

  result_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .wr_vld (push_req),
    .wr_dat (cand),
    .rd_rdy (OUT_READY),
    .rd_dat (head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign OUT_VALID = !fifo_empty;
  assign FIFO_FULL = fifo_full;
  assign OUT_DATA  = WIDTH_OUT_DATA_ARITH'(head.data);
  assign OUT_TAG   = head.tag;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector with a queue scoreboard and a decoupled output monitor.
// Latency: n/a.
// Backpressure: exercised through OUT_READY patterns.
module tb_alu_result_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic [15:0] Logic_OUT;
  logic [15:0] CMP_OUT;
  logic [15:0] SHIFT_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic [31:0] OUT_DATA;
  logic [1:0]  OUT_TAG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        FIFO_FULL;
  logic [7:0]  DROP_CNT;
  logic        MULTI_ERR;

  always #5 CLK = ~CLK;

  alu_result_collector dut (
    .CLK        (CLK),
    .RST        (RST),
    .Arith_OUT  (Arith_OUT),
    .Logic_OUT  (Logic_OUT),
    .CMP_OUT    (CMP_OUT),
    .SHIFT_OUT  (SHIFT_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .SHIFT_Flag (SHIFT_Flag),
    .OUT_DATA   (OUT_DATA),
    .OUT_TAG    (OUT_TAG),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .FIFO_FULL  (FIFO_FULL),
    .DROP_CNT   (DROP_CNT),
    .MULTI_ERR  (MULTI_ERR)
  );

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   n_pops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] tag, input logic [31:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_flags();
    Arith_Flag = 1'b0;
    Logic_Flag = 1'b0;
    CMP_Flag   = 1'b0;
    SHIFT_Flag = 1'b0;
  endtask

  initial begin
    int pops_before;
    int exp_hold;
    checks     = 0;
    failures   = 0;
    n_pops     = 0;
    RST        = 1'b1;
    OUT_READY  = 1'b0;
    Arith_OUT  = '0;
    Logic_OUT  = '0;
    CMP_OUT    = '0;
    SHIFT_OUT  = '0;
    clear_flags();

    // Monitor: whatever the DUT hands over must be the next scoreboard entry.
    fork
      forever begin
        exp_t e;
        @(negedge CLK);
        if (!RST && OUT_VALID && OUT_READY) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected got tag=%0d data=%h expected no entry", OUT_TAG, OUT_DATA);
          end else begin
            e = exp_q.pop_front();
            chk("mon_data", OUT_DATA, e.data);
            chk("mon_tag", 32'(OUT_TAG), 32'(e.tag));
          end
        end
      end
    join_none

    // Reset state.
    tick(2);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_tag", 32'(OUT_TAG), 32'd0);
    chk("rst_full", 32'(FIFO_FULL), 32'd0);
    chk("rst_drop", 32'(DROP_CNT), 32'd0);
    chk("rst_multi", 32'(MULTI_ERR), 32'd0);
    RST = 1'b0;
    tick();

    // Arith passes through unchanged, one-cycle latency.
    OUT_READY  = 1'b1;
    Arith_Flag = 1'b1;
    Arith_OUT  = 32'hFFFF_FFF4;
    push_exp(2'b00, 32'hFFFF_FFF4);
    tick();
    clear_flags();
    chk("lat_valid", 32'(OUT_VALID), 32'd1);
    chk("lat_data", OUT_DATA, 32'hFFFF_FFF4);
    chk("lat_tag", 32'(OUT_TAG), 32'd0);
    tick();

    // Logic is zero-extended.
    Logic_Flag = 1'b1;
    Logic_OUT  = 16'hFFF8;
    push_exp(2'b01, 32'h0000_FFF8);
    tick();
    clear_flags();
    chk("logic_data", OUT_DATA, 32'h0000_FFF8);
    tick();

    // Two flags at once: arith wins, MULTI_ERR sets.
    Arith_Flag = 1'b1;
    Arith_OUT  = 32'h1234_5678;
    SHIFT_Flag = 1'b1;
    SHIFT_OUT  = 16'h00AB;
    push_exp(2'b00, 32'h1234_5678);
    tick();
    clear_flags();
    chk("multi_set", 32'(MULTI_ERR), 32'd1);
    tick();

    // Fill with backpressure: six distinct results, four stored, two dropped.
    OUT_READY = 1'b0;
    Arith_Flag = 1'b1; Arith_OUT = 32'd1; push_exp(2'b00, 32'd1); tick(); clear_flags();
    Logic_Flag = 1'b1; Logic_OUT = 16'd2; push_exp(2'b01, 32'd2); tick(); clear_flags();
    CMP_Flag   = 1'b1; CMP_OUT   = 16'd3; push_exp(2'b10, 32'd3); tick(); clear_flags();
    SHIFT_Flag = 1'b1; SHIFT_OUT = 16'd4; push_exp(2'b11, 32'd4); tick(); clear_flags();
    Arith_Flag = 1'b1; Arith_OUT = 32'd5; tick(); clear_flags();
    Logic_Flag = 1'b1; Logic_OUT = 16'd6; tick(); clear_flags();
    chk("full_flag", 32'(FIFO_FULL), 32'd1);
    chk("full_drop", 32'(DROP_CNT), 32'd2);
    chk("full_hold_data", OUT_DATA, 32'd1);

    // Push and pop together at full: accepted, no drop, still full.
    OUT_READY = 1'b1;
    CMP_Flag  = 1'b1;
    CMP_OUT   = 16'h0077;
    push_exp(2'b10, 32'h0000_0077);
    tick();
    clear_flags();
    OUT_READY = 1'b0;
    chk("pp_full", 32'(FIFO_FULL), 32'd1);
    chk("pp_drop", 32'(DROP_CNT), 32'd2);
    chk("multi_sticky", 32'(MULTI_ERR), 32'd1);

    // Drain in push order.
    OUT_READY = 1'b1;
    tick(4);
    chk("drain_valid", 32'(OUT_VALID), 32'd0);
    chk("drain_full", 32'(FIFO_FULL), 32'd0);
    chk("drain_empty_data", OUT_DATA, 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-operation discards the stored entry.
    OUT_READY  = 1'b0;
    Arith_Flag = 1'b1;
    Arith_OUT  = 32'h0000_000A;
    tick();
    clear_flags();
    chk("pre_rst_valid", 32'(OUT_VALID), 32'd1);
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_drop", 32'(DROP_CNT), 32'd0);
    chk("arst_multi", 32'(MULTI_ERR), 32'd0);
    tick();
    RST = 1'b0;
    tick();

    // Held CMP result for five cycles.
`ifdef ALU_RESULT_DEDUP_EN
    exp_hold = 1;
`else
    exp_hold = 5;
`endif
    for (int i = 0; i < exp_hold; i++) push_exp(2'b10, 32'h0000_0003);
    pops_before = n_pops;
    OUT_READY = 1'b1;
    CMP_Flag  = 1'b1;
    CMP_OUT   = 16'h0003;
    tick(5);
    clear_flags();
    tick(3);
    chk("hold_entries", 32'(n_pops - pops_before), 32'(exp_hold));
    chk("hold_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Consumer-side block for the ALU: samples the registered, flag-qualified outputs of `ALU_TOP` (Arith/Logic/CMP/SHIFT plus their flags) and converts them into a tagged result stream. Results are buffered in a small FIFO and drained over a valid/ready handshake. It sits between `ALU_TOP` and any downstream result sink (bus bridge, UART framer, scoreboard port).

## Interface
- WIDTH_OUT_DATA_ARITH, 32, width of Arith_OUT; also the output data width
- WIDTH_OUT_DATA_LOGIC, 16, width of Logic_OUT
- WIDTH_OUT_DATA_CMP, 16, width of CMP_OUT
- WIDTH_OUT_DATA_SHIFT, 16, width of SHIFT_OUT
- FIFO_DEPTH, 4, result FIFO entries, power of two, ≥2
---
- One clock; reset is asynchronous and active-high.
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- Arith_OUT  in  WIDTH_OUT_DATA_ARITH  signed arithmetic result
- Logic_OUT  in  WIDTH_OUT_DATA_LOGIC  logic result
- CMP_OUT  in  WIDTH_OUT_DATA_CMP  compare result
- SHIFT_OUT  in  WIDTH_OUT_DATA_SHIFT  shift result
- Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  result-valid qualifiers
- OUT_DATA  out  WIDTH_OUT_DATA_ARITH  head-of-FIFO result
- OUT_TAG  out  2  head-of-FIFO class: 00 arith, 01 logic, 10 cmp, 11 shift
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  sink accepts head this cycle
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries
- DROP_CNT  out  8  results lost to a full FIFO, saturating
- MULTI_ERR  out  1  sticky: more than one flag seen high in a cycle

## Operation
- Each rising edge: if any flag is high, a candidate is formed. Priority is Arith > Logic > CMP > SHIFT.
- Candidate data:
  - Arith_OUT is passed unchanged.
  - Logic/CMP/SHIFT results are zero-extended to WIDTH_OUT_DATA_ARITH.
- More than one flag high in a cycle: the highest-priority candidate is used and MULTI_ERR is set. MULTI_ERR clears only on RST.
- Candidate push: into the FIFO if not full (subject to Configuration). If full and no pop occurs this cycle: the candidate is discarded and DROP_CNT increments, saturating at 255.
- Pop: OUT_VALID && OUT_READY at a rising edge removes the head.
- Push and pop in the same cycle:
  - Both are performed; count is unchanged.
  - At full, the push is accepted, not dropped.
  - At empty, only the push occurs; the pop is impossible because OUT_VALID=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is held separately in log2(FIFO_DEPTH)+1 bits.
- OUT_DATA/OUT_TAG are first-word-fall-through from the head entry. They read as 0 when empty.
- All flags low: no action.

## Timing
- Reset values: OUT_DATA 0, OUT_TAG 00, OUT_VALID 0, FIFO_FULL 0, DROP_CNT 0, MULTI_ERR 0. FIFO empty; dedup history invalid.
- RST asserted mid-operation discards all entries immediately (asynchronous); no partial pop completes.
- Latency: flag sampled at edge k into an empty FIFO → OUT_VALID=1 and data valid after edge k, i.e. 1 cycle.
- Throughput: one push and one pop per cycle.
- FIFO_FULL, OUT_VALID: registered-count decodes that update on the edge that changes count.
- OUT_DATA and OUT_TAG are held stable while OUT_VALID=1 and OUT_READY=0.

## Configuration
- ALU_RESULT_DEDUP_EN defined:
  - A candidate is pushed only if its {class, data} differs from the last accepted push, or if no push has happened since reset.
  - Dropped candidates do not update the history.
  - Because ALU outputs hold across cycles, a steady operation yields one entry.
- ALU_RESULT_DEDUP_EN undefined: every flagged cycle produces a candidate, and there is no history register.

## Structure
- Package alu_result_pkg:
  - class codes CLS_ARITH=2'b00, CLS_LOGIC=2'b01, CLS_CMP=2'b10, CLS_SHIFT=2'b11
  - DROP_CNT_W=8
  - entry typedef {tag, data}
- Sub-module result_fifo: synchronous FIFO with FWFT head, full/empty/count, and async active-high reset. It is instantiated once.
- The top holds the priority select, zero-extension, dedup history, drop counter and MULTI_ERR.

## Test plan
- Reset, then Arith_Flag=1 with Arith_OUT=32'hFFFFFFF4, OUT_READY=1 → after one edge OUT_VALID=1, OUT_DATA=FFFFFFF4, OUT_TAG=00.
- Logic_Flag=1, Logic_OUT=16'hFFF8 → OUT_DATA=0000FFF8 (zero-extended), OUT_TAG=01.
- Arith_Flag and SHIFT_Flag high together → arith entry pushed, MULTI_ERR=1 and stays 1 until RST.
- OUT_READY=0, six distinct flagged results with FIFO_DEPTH=4 → FIFO_FULL=1, DROP_CNT=2. Entries then drain in push order.
- At full, with push and pop in the same cycle → count stays 4, no drop.
- With ALU_RESULT_DEDUP_EN: CMP_Flag held 5 cycles with CMP_OUT=16'h0003 → exactly one entry. Without the macro → five entries.
